// File: rtl/adt7310_spi_responder.sv
// ADT7310 temperature sensor emulator: SPI mode-3 target with status/config/temp/ID registers
// and a one-shot conversion timer that loads Temperature_i when it expires.
`timescale 1ns/1ps
module adt7310_spi_responder #(
  parameter logic [7:0] IdValue = 8'hC3
) (
  input  logic        Reset_n_i,
  input  logic        Clk_i,
  input  logic        SCK_i,
  input  logic        CS_n_i,
  input  logic        MOSI_i,
  output logic        MISO_o,
  input  logic [15:0] Temperature_i,
  input  logic [15:0] ConvTime_i,
  output logic [7:0]  ConfigReg_o,
  output logic        Busy_o,
  output logic        TempUpdated_o
);

  // state      | meaning
  // st_idle    | CS_n high, nothing in progress
  // st_cmd     | shifting in the command byte
  // st_wr_data | shifting in the single write data byte
  // st_rd_data | shifting register contents out on MISO
  // st_ignore  | discarding bits until CS_n rises
  typedef enum logic [2:0] {st_idle, st_cmd, st_wr_data, st_rd_data, st_ignore} state_t;

  state_t      state, state_nxt;
  logic [2:0]  sck_q;
  logic [1:0]  cs_q, mosi_q;
  logic        sck_rise, sck_fall, cs_n, mosi;
  logic [2:0]  bit_cnt, addr;
  logic [6:0]  rx_sh;
  logic [7:0]  byte_in;
  logic [15:0] tx_sh, rd_load, temp_reg, timer;
  logic        rdy_n;
  logic        cmd_done, decode_rd, wr_cfg, rd_temp_done, conv_done;

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      sck_q  <= 3'b111;
      cs_q   <= 2'b11;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], SCK_i};
      cs_q   <= {cs_q[0], CS_n_i};
      mosi_q <= {mosi_q[0], MOSI_i};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_n     = cs_q[1];
  assign mosi     = mosi_q[1];
  assign byte_in  = {rx_sh, mosi};

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) state <= st_idle;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cmd_done     = 1'b0;
    decode_rd    = 1'b0;
    wr_cfg       = 1'b0;
    rd_temp_done = 1'b0;
    if (cs_n) begin
      state_nxt = st_idle;
    end else begin
      case (state)
        st_idle: state_nxt = st_cmd;
        st_cmd:
          if (sck_rise && bit_cnt == 3'd7) begin
            cmd_done = 1'b1;
            if (byte_in[6]) begin
              decode_rd = 1'b1;
              state_nxt = st_rd_data;
            end else begin
              state_nxt = st_wr_data;
            end
          end
        st_wr_data:
          if (sck_rise && bit_cnt == 3'd7) begin
            wr_cfg    = (addr == 3'd1);
            state_nxt = st_ignore;
          end
        st_rd_data: rd_temp_done = sck_rise && (bit_cnt == 3'd7) && (addr == 3'd2);
        default: ;
      endcase
    end
  end

  // 8-bit registers are padded with 0xFF so trailing bytes read as all ones
  always_comb begin
    case (byte_in[5:3])
      3'd0:    rd_load = {rdy_n, 7'b0, 8'hFF};
      3'd1:    rd_load = {ConfigReg_o, 8'hFF};
      3'd2:    rd_load = temp_reg;
      3'd3:    rd_load = {IdValue, 8'hFF};
      default: rd_load = {8'h00, 8'hFF};
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      bit_cnt <= 3'd0;
      rx_sh   <= 7'd0;
      addr    <= 3'd0;
      tx_sh   <= 16'hFFFF;
      MISO_o  <= 1'b1;
    end else if (cs_n) begin
      bit_cnt <= 3'd0;
      MISO_o  <= 1'b1;
    end else begin
      if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sh   <= {rx_sh[5:0], mosi};
      end
      if (cmd_done) addr <= byte_in[5:3];
      if (decode_rd) begin
        tx_sh <= rd_load;
      end else if (state == st_rd_data && sck_fall) begin
        MISO_o <= tx_sh[15];
        tx_sh  <= {tx_sh[14:0], 1'b1};
      end
    end
  end

  // A config write in the same cycle as expiry takes precedence over the completion
  assign conv_done = Busy_o && (timer == 16'd0) && !wr_cfg;

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      ConfigReg_o   <= 8'h00;
      Busy_o        <= 1'b0;
      TempUpdated_o <= 1'b0;
      timer         <= 16'd0;
      temp_reg      <= 16'h0000;
      rdy_n         <= 1'b1;
    end else begin
      TempUpdated_o <= 1'b0;
      if (wr_cfg) begin
        ConfigReg_o <= byte_in;
        Busy_o      <= (byte_in[6:5] == 2'b01);
        timer       <= ConvTime_i;
      end else if (conv_done) begin
        temp_reg         <= Temperature_i;
        ConfigReg_o[6:5] <= 2'b11;
        Busy_o           <= 1'b0;
        TempUpdated_o    <= 1'b1;
      end else if (Busy_o) begin
        timer <= timer - 16'd1;
      end
      if (conv_done)         rdy_n <= 1'b0;
      else if (rd_temp_done) rdy_n <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adt7310_spi_responder.sv
// Bench for the ADT7310 emulator: directed read table, multi-cycle corner sequences and
// randomized transactions checked against a register-level model of the sensor.
`timescale 1ns/1ps
module tb_adt7310_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b1, cs_n = 1'b1, mosi = 1'b0;
  logic        miso;
  logic [15:0] temperature = 16'h0000, conv_time = 16'd0;
  logic [7:0]  config_reg;
  logic        busy, temp_updated;

  adt7310_spi_responder #(.IdValue(8'hC3)) dut (
    .Reset_n_i(rst_n), .Clk_i(clk), .SCK_i(sck), .CS_n_i(cs_n), .MOSI_i(mosi),
    .MISO_o(miso), .Temperature_i(temperature), .ConvTime_i(conv_time),
    .ConfigReg_o(config_reg), .Busy_o(busy), .TempUpdated_o(temp_updated)
  );

  always #5 clk = ~clk;

  int busy_total = 0, tu_total = 0;
  always @(negedge clk) begin
    if (busy)         busy_total <= busy_total + 1;
    if (temp_updated) tu_total   <= tu_total + 1;
  end

  int n_checks = 0, n_pass = 0;
  logic [7:0]  tx_buf [4];
  logic [7:0]  rx_buf [4];

  // register-level model of the sensor
  logic [7:0]  m_cfg;
  logic        m_rdy;
  logic [15:0] m_temp;

  typedef struct {
    logic [7:0]  cmd;
    int          ndata;
    logic [23:0] exp;
    string       name;
  } rd_vec_t;
  rd_vec_t vecs [8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic xfer(input int nbytes, input int nbits);
    cs_n = 1'b0;
    #200;
    for (int k = 0; k < nbytes * 8 && k < nbits; k++) begin
      sck  = 1'b0;
      mosi = tx_buf[k / 8][7 - (k % 8)];
      #80;
      rx_buf[k / 8][7 - (k % 8)] = miso;
      sck = 1'b1;
      #80;
    end
    #200;
    cs_n = 1'b1;
    #200;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] cmd, input int ndata);
    tx_buf[0] = cmd;
    for (int i = 1; i < 4; i++) tx_buf[i] = 8'hFF;
    xfer(ndata + 1, (ndata + 1) * 8);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d0, input logic [7:0] d1, input int ndata);
    tx_buf[0] = {2'b00, a, 3'b000};
    tx_buf[1] = d0;
    tx_buf[2] = d1;
    xfer(ndata + 1, (ndata + 1) * 8);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    #1;
    check(name, {15'd0, busy}, 16'd0);
  endtask

  function automatic logic [7:0] model_byte(input logic [2:0] a, input int j);
    logic [15:0] r;
    case (a)
      3'd0:    r = {m_rdy, 7'b0, 8'hFF};
      3'd1:    r = {m_cfg, 8'hFF};
      3'd2:    r = m_temp;
      3'd3:    r = 16'hC3FF;
      default: r = 16'h00FF;
    endcase
    if (j == 1) return r[15:8];
    if (j == 2) return r[7:0];
    return 8'hFF;
  endfunction

  task automatic oneshot(input logic [7:0] v, input logic [15:0] ct, input logic [15:0] t, input string name);
    int b0, t0;
    conv_time   = ct;
    temperature = t;
    b0 = busy_total;
    t0 = tu_total;
    do_write(3'd1, v, 8'hFF, 1);
    wait_idle({name, "_done"});
    check({name, "_busy_len"}, 16'(busy_total - b0), ct + 16'd1);
    check({name, "_tu_pulses"}, 16'(tu_total - t0), 16'd1);
    m_cfg  = v | 8'h60;
    m_temp = t;
    m_rdy  = 1'b0;
    check({name, "_cfg"}, {8'h00, config_reg}, {8'h00, m_cfg});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0, t0, ok;
    vecs[0] = '{8'h40, 1, 24'h00FFFF, "stat_pre"};
    vecs[1] = '{8'h50, 2, 24'h0C80FF, "temp_rd"};
    vecs[2] = '{8'h40, 1, 24'h80FFFF, "stat_post"};
    vecs[3] = '{8'h58, 2, 24'hC3FFFF, "id_rd"};
    vecs[4] = '{8'h68, 1, 24'h00FFFF, "addr5_rd"};
    vecs[5] = '{8'h48, 2, 24'h60FFFF, "cfg_rd"};
    vecs[6] = '{8'h50, 3, 24'h0C80FF, "temp_3b"};
    vecs[7] = '{8'hCF, 1, 24'h60FFFF, "cfg_junk_bits"};

    repeat (5) @(negedge clk);
    check("rst_miso", {15'd0, miso}, 16'd1);
    check("rst_cfg", {8'd0, config_reg}, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_tu", {15'd0, temp_updated}, 16'd0);
    rst_n = 1'b1;

    // SCK activity with CS_n high must be ignored
    ok = 1;
    for (int k = 0; k < 16; k++) begin
      sck  = 1'b0;
      mosi = (k == 4 || k == 10) ? 1'b1 : 1'b0;
      #80;
      if (miso !== 1'b1) ok = 0;
      sck = 1'b1;
      #80;
    end
    @(negedge clk);
    check("cs_high_miso", ok[15:0], 16'd1);
    check("cs_high_cfg", {8'd0, config_reg}, 16'h0000);
    check("cs_high_busy", {15'd0, busy}, 16'd0);
    do_read(8'h40, 1);
    check("rst_status", {8'd0, rx_buf[1]}, 16'h0080);
    check("rst_status_b0", {8'd0, rx_buf[0]}, 16'h00FF);
    do_read(8'h50, 2);
    check("rst_temp", {rx_buf[1], rx_buf[2]}, 16'h0000);

    // one-shot with ConvTime 100
    conv_time   = 16'd100;
    temperature = 16'h0C80;
    b0 = busy_total;
    t0 = tu_total;
    do_write(3'd1, 8'h20, 8'hFF, 1);
    check("os_cfg_during", {8'd0, config_reg}, 16'h0020);
    check("os_busy_during", {15'd0, busy}, 16'd1);
    wait_idle("os_done");
    check("os_busy_len", 16'(busy_total - b0), 16'd101);
    check("os_tu_pulses", 16'(tu_total - t0), 16'd1);
    check("os_cfg_after", {8'd0, config_reg}, 16'h0060);

    foreach (vecs[i]) begin
      do_read(vecs[i].cmd, vecs[i].ndata);
      check({vecs[i].name, "_b0"}, {8'd0, rx_buf[0]}, 16'h00FF);
      for (int j = 1; j <= vecs[i].ndata; j++)
        check($sformatf("%s_b%0d", vecs[i].name, j), {8'd0, rx_buf[j]},
              {8'd0, vecs[i].exp[31 - 8 * j -: 8]});
      check({vecs[i].name, "_miso_idle"}, {15'd0, miso}, 16'd1);
    end
    m_cfg = 8'h60; m_rdy = 1'b1; m_temp = 16'h0C80;

    // CS_n raised mid-byte: write must be dropped
    b0 = busy_total;
    tx_buf[0] = 8'h08; tx_buf[1] = 8'h20;
    xfer(2, 13);
    repeat (5) @(negedge clk);
    check("abort_cfg", {8'd0, config_reg}, {8'd0, m_cfg});
    check("abort_busy", 16'(busy_total - b0), 16'd0);

    // ConvTime 0: one busy cycle
    oneshot(8'h20, 16'd0, 16'h1234, "ct0");

    // second write byte in the same transaction is ignored
    do_write(3'd1, 8'h05, 8'h20, 2);
    m_cfg = 8'h05;
    check("one_wr_byte_cfg", {8'd0, config_reg}, 16'h0005);
    check("one_wr_byte_busy", {15'd0, busy}, 16'd0);

    // non-one-shot config write aborts a running conversion
    conv_time = 16'd1000;
    temperature = 16'hBEEF;
    t0 = tu_total;
    do_write(3'd1, 8'h20, 8'hFF, 1);
    check("cancel_busy_on", {15'd0, busy}, 16'd1);
    do_write(3'd1, 8'h00, 8'hFF, 1);
    check("cancel_busy_off", {15'd0, busy}, 16'd0);
    repeat (1100) @(negedge clk);
    check("cancel_no_tu", 16'(tu_total - t0), 16'd0);
    check("cancel_cfg", {8'd0, config_reg}, 16'h0000);
    m_cfg = 8'h00;
    do_read(8'h50, 2);
    check("cancel_temp", {rx_buf[1], rx_buf[2]}, m_temp);
    m_rdy = 1'b1;

    // randomized transactions against the model
    for (int it = 0; it < 24; it++) begin
      int op = $urandom_range(0, 2);
      logic [2:0] a = 3'($urandom_range(0, 7));
      logic [7:0] v = 8'($urandom);
      if (op == 0) begin
        int nd = $urandom_range(1, 3);
        logic [7:0] cmd = {v[7], 1'b1, a, v[2:0]};
        do_read(cmd, nd);
        check($sformatf("rnd%0d_rd_b0", it), {8'd0, rx_buf[0]}, 16'h00FF);
        for (int j = 1; j <= nd; j++)
          check($sformatf("rnd%0d_rd_a%0d_b%0d", it, a, j), {8'd0, rx_buf[j]},
                {8'd0, model_byte(a, j)});
        if (a == 3'd2) m_rdy = 1'b1;
      end else if (op == 1) begin
        if (v[6:5] == 2'b01) v[5] = 1'b0;
        do_write(a, v, 8'($urandom), $urandom_range(1, 2));
        if (a == 3'd1) m_cfg = v;
        check($sformatf("rnd%0d_wr_cfg", it), {8'd0, config_reg}, {8'd0, m_cfg});
        check($sformatf("rnd%0d_wr_busy", it), {15'd0, busy}, 16'd0);
      end else begin
        v[6:5] = 2'b01;
        oneshot(v, 16'($urandom_range(0, 30)), 16'($urandom), $sformatf("rnd%0d_os", it));
      end
    end

    // reset during a conversion
    conv_time = 16'd1000;
    temperature = 16'h7777;
    do_write(3'd1, 8'h20, 8'hFF, 1);
    check("rstconv_busy_on", {15'd0, busy}, 16'd1);
    t0 = tu_total;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rstconv_busy", {15'd0, busy}, 16'd0);
    check("rstconv_cfg", {8'd0, config_reg}, 16'h0000);
    rst_n = 1'b1;
    repeat (1100) @(negedge clk);
    check("rstconv_no_tu", 16'(tu_total - t0), 16'd0);
    do_read(8'h50, 2);
    check("rstconv_temp", {rx_buf[1], rx_buf[2]}, 16'h0000);
    do_read(8'h40, 1);
    check("rstconv_status", {8'd0, rx_buf[1]}, 16'h0080);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
